// File: rtl/logic_pkg.sv
// logic_pkg: funct encodings shared by the logic unit and its combinational core.
// LOGIC_UNIT_POPCNT_EN turns code 111 from ANDN into population count.
package logic_pkg;
    localparam int LF_FUNCT_W = 3;
    localparam logic [LF_FUNCT_W-1:0] LF_OR   = 3'b000;
    localparam logic [LF_FUNCT_W-1:0] LF_AND  = 3'b001;
    localparam logic [LF_FUNCT_W-1:0] LF_XOR  = 3'b010;
    localparam logic [LF_FUNCT_W-1:0] LF_NOTA = 3'b011;
    localparam logic [LF_FUNCT_W-1:0] LF_NOR  = 3'b100;
    localparam logic [LF_FUNCT_W-1:0] LF_NAND = 3'b101;
    localparam logic [LF_FUNCT_W-1:0] LF_XNOR = 3'b110;
`ifdef LOGIC_UNIT_POPCNT_EN
    localparam logic [LF_FUNCT_W-1:0] LF_POPCNT = 3'b111;
`else
    localparam logic [LF_FUNCT_W-1:0] LF_ANDN = 3'b111;
`endif
endpackage

// File: rtl/logic_op_comb.sv
// logic_op_comb: purely combinational bitwise operation core (a, b, funct -> res).
// LOGIC_UNIT_POPCNT_EN replaces ANDN with popcount(a) on funct 111.
module logic_op_comb
    import logic_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]      a,
    input  logic [WIDTH-1:0]      b,
    input  logic [LF_FUNCT_W-1:0] funct,
    output logic [WIDTH-1:0]      res
);
`ifdef LOGIC_UNIT_POPCNT_EN
    localparam int CW = $clog2(WIDTH + 1);
    logic [CW-1:0] cnt;
    always_comb begin
        cnt = '0;
        for (int i = 0; i < WIDTH; i++) cnt = cnt + CW'(a[i]);
    end
`endif
    always_comb begin
        case (funct)
            LF_OR:     res = a | b;
            LF_AND:    res = a & b;
            LF_XOR:    res = a ^ b;
            LF_NOTA:   res = ~a;
            LF_NOR:    res = ~(a | b);
            LF_NAND:   res = ~(a & b);
            LF_XNOR:   res = ~(a ^ b);
`ifdef LOGIC_UNIT_POPCNT_EN
            LF_POPCNT: res = WIDTH'(cnt);
`else
            LF_ANDN:   res = a & ~b;
`endif
            default:   res = '0;
        endcase
    end
endmodule

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage pipelined logic unit with valid/ready on both sides.
// LOGIC_UNIT_POPCNT_EN selects popcount instead of ANDN for funct 111.
module logic_unit_pipe
    import logic_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_a,
    input  logic [WIDTH-1:0]      in_b,
    input  logic [LF_FUNCT_W-1:0] in_funct,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_res,
    output logic [TAG_W-1:0]      out_tag,
    output logic                  out_zero,
    output logic                  out_neg,
    output logic                  out_parity
);
    logic                  s1_valid, s2_valid, s1_adv, s2_adv;
    logic [WIDTH-1:0]      s1_a, s1_b, res;
    logic [LF_FUNCT_W-1:0] s1_funct;
    logic [TAG_W-1:0]      s1_tag;
    assign s2_adv = !s2_valid || out_ready;
    assign s1_adv = !s1_valid || s2_adv;
    // Both handshakes are masked while reset is high so no transfer can occur that cycle.
    assign in_ready  = s1_adv && !reset;
    assign out_valid = s2_valid && !reset;
    always_ff @(posedge clk) begin
        if (reset) s1_valid <= 1'b0;
        else if (s1_adv) s1_valid <= in_valid;
    end
    always_ff @(posedge clk) begin
        if (s1_adv) begin
            s1_a     <= in_a;
            s1_b     <= in_b;
            s1_funct <= in_funct;
            s1_tag   <= in_tag;
        end
    end
    logic_op_comb #(.WIDTH(WIDTH)) u_op (
        .a     (s1_a),
        .b     (s1_b),
        .funct (s1_funct),
        .res   (res)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid   <= 1'b0;
            out_res    <= '0;
            out_tag    <= '0;
            out_zero   <= 1'b0;
            out_neg    <= 1'b0;
            out_parity <= 1'b0;
        end else if (s2_adv) begin
            s2_valid   <= s1_valid;
            out_res    <= res;
            out_tag    <= s1_tag;
            out_zero   <= ~|res;
            out_neg    <= res[WIDTH-1];
            out_parity <= ^res;
        end
    end
endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: randomized scoreboard bench for logic_unit_pipe against a truth-table model.
module tb_logic_unit_pipe;
    localparam int WIDTH = 32;
    localparam int TAG_W = 5;
    logic clk = 1'b0;
    logic reset, in_valid, in_ready, out_valid, out_ready, out_zero, out_neg, out_parity;
    logic [WIDTH-1:0] in_a, in_b, out_res;
    logic [2:0] in_funct;
    logic [TAG_W-1:0] in_tag, out_tag;
    int total = 0;
    int bad = 0;
    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic [TAG_W-1:0] tag;
    } item_t;
    item_t exp_q[$];

    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_funct(in_funct), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res), .out_tag(out_tag),
        .out_zero(out_zero), .out_neg(out_neg), .out_parity(out_parity)
    );

    // Each funct owns a 4-entry truth table indexed by {a_bit, b_bit}.
    function automatic logic [WIDTH-1:0] ref_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [2:0] f);
        logic [31:0] luts;
        logic [WIDTH-1:0] r;
        luts = 32'h4971_368E;
`ifdef LOGIC_UNIT_POPCNT_EN
        if (f == 3'd7) return WIDTH'($countones(a));
`endif
        for (int i = 0; i < WIDTH; i++) r[i] = luts[{f, a[i], b[i]}];
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_in;
        item_t it;
        it.res = ref_op(in_a, in_b, in_funct);
        it.tag = in_tag;
        exp_q.push_back(it);
    endtask

    task automatic test_reset;
        reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        in_a = '0; in_b = '0; in_funct = '0; in_tag = '0;
        repeat (3) tick;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            bad++; $display("FAIL reset_hs: out_valid=%b in_ready=%b want 0 0", out_valid, in_ready);
        end
        total++;
        if ({out_res, out_tag, out_zero, out_neg, out_parity} !== '0) begin
            bad++; $display("FAIL reset_out: res=%h tag=%h z=%b n=%b p=%b want all 0", out_res, out_tag, out_zero, out_neg, out_parity);
        end
        in_valid = 1'b0; reset = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: in_ready=%b want 1", in_ready); end
        tick;
    endtask

    task automatic test_op_sweep;
        logic [WIDTH-1:0] sweep [8];
        sweep = '{32'hFFF0_12FF, 32'h00F0_0034, 32'hFF00_12CB, 32'h0F0F_EDCB,
                  32'h000F_ED00, 32'hFF0F_FFCB, 32'h00FF_ED34, 32'hF000_1200};
`ifdef LOGIC_UNIT_POPCNT_EN
        sweep[7] = 32'h0000_000D;
`endif
        out_ready = 1'b1;
        for (int f = 0; f < 8; f++) begin
            in_a = 32'hF0F0_1234; in_b = 32'h0FF0_00FF; in_funct = 3'(f); in_tag = 5'd7; in_valid = 1'b1;
            #1;
            total++;
            if (in_ready !== 1'b1) begin bad++; $display("FAIL sweep_ready f=%0d: in_ready=%b want 1", f, in_ready); end
            tick;
            in_valid = 1'b0;
            total++;
            if (out_valid !== 1'b0) begin bad++; $display("FAIL sweep_early f=%0d: out_valid=%b want 0", f, out_valid); end
            tick;
            total++;
            if (out_valid !== 1'b1 || out_res !== sweep[f] || out_tag !== 5'd7) begin
                bad++; $display("FAIL sweep f=%0d: valid=%b res=%h tag=%0d want 1 %h 7", f, out_valid, out_res, out_tag, sweep[f]);
            end
            tick;
        end
    endtask

    task automatic test_flags;
        logic [WIDTH-1:0] fa [2], fb [2], fr [2];
        logic [2:0] ff [2], fl [2];
        fa = '{32'h0, 32'h8000_0001}; fb = '{32'h0, 32'h0}; ff = '{3'd2, 3'd0};
        fr = '{32'h0, 32'h8000_0001}; fl = '{3'b100, 3'b010};
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_a = fa[k]; in_b = fb[k]; in_funct = ff[k]; in_tag = 5'(k); in_valid = 1'b1;
            tick;
            in_valid = 1'b0;
            tick;
            total++;
            if (out_valid !== 1'b1 || out_res !== fr[k] || {out_zero, out_neg, out_parity} !== fl[k]) begin
                bad++; $display("FAIL flags k=%0d: valid=%b res=%h znp=%b%b%b want 1 %h %b", k, out_valid, out_res, out_zero, out_neg, out_parity, fr[k], fl[k]);
            end
            tick;
        end
    endtask

    task automatic test_backpressure;
        int sent = 0, got = 0;
        bit saw_block = 0, stalled = 0;
        logic [WIDTH-1:0] hold_res = '0;
        logic [TAG_W-1:0] hold_tag = '0;
        item_t e;
        exp_q.delete();
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            out_ready = !(cyc >= 3 && cyc <= 6);
            in_valid = (sent < 6); in_tag = TAG_W'(sent + 1);
            in_a = $urandom; in_b = $urandom; in_funct = 3'($urandom_range(0, 7));
            #1;
            if (stalled) begin
                total++;
                if (out_valid !== 1'b1 || out_res !== hold_res || out_tag !== hold_tag) begin
                    bad++; $display("FAIL bp_stable cyc=%0d: valid=%b res=%h tag=%0d want 1 %h %0d", cyc, out_valid, out_res, out_tag, hold_res, hold_tag);
                end
            end
            if (!in_ready) saw_block = 1;
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL bp_extra: tag=%0d want none", out_tag); end
                else begin
                    e = exp_q.pop_front();
                    if (out_res !== e.res || out_tag !== e.tag) begin
                        bad++; $display("FAIL bp_data: res=%h tag=%0d want %h %0d", out_res, out_tag, e.res, e.tag);
                    end
                end
                got++;
            end
            stalled = out_valid && !out_ready; hold_res = out_res; hold_tag = out_tag;
            if (in_valid && in_ready) begin push_in(); sent++; end
            tick;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        total++;
        if (got != 6 || exp_q.size() != 0) begin bad++; $display("FAIL bp_count: got=%0d left=%0d want 6 0", got, exp_q.size()); end
        total++;
        if (!saw_block) begin bad++; $display("FAIL bp_in_ready: in_ready never %0d want drop to 0", 0); end
    endtask

    task automatic test_streaming;
        item_t e;
        exp_q.delete();
        out_ready = 1'b0;
        for (int c = 0; c < 22 + 10; c++) begin
            in_valid = (c < 22); out_ready = (c >= 2);
            in_a = $urandom; in_b = $urandom; in_funct = 3'($urandom_range(0, 7)); in_tag = 5'($urandom);
            #1;
            if (c >= 2 && c < 22) begin
                total++;
                if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
                    bad++; $display("FAIL stream c=%0d: in_ready=%b out_valid=%b want 1 1", c, in_ready, out_valid);
                end
            end
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL stream_extra: tag=%0d want none", out_tag); end
                else begin
                    e = exp_q.pop_front();
                    if (out_res !== e.res || out_tag !== e.tag) begin
                        bad++; $display("FAIL stream_data: res=%h tag=%0d want %h %0d", out_res, out_tag, e.res, e.tag);
                    end
                end
            end
            if (in_valid && in_ready) push_in();
            tick;
        end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL stream_left: %0d want 0", exp_q.size()); end
    endtask

    task automatic test_reset_midflight;
        out_ready = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_a = $urandom; in_b = $urandom; in_funct = 3'($urandom_range(0, 7)); in_tag = TAG_W'(21 + k);
            tick;
        end
        in_valid = 1'b0; out_ready = 1'b1; reset = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_hold: out_valid=%b want 0", out_valid); end
        tick;
        reset = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_after: out_valid=%b want 0", out_valid); end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_ghost k=%0d: out_valid=%b tag=%0d want 0", k, out_valid, out_tag); end
            tick;
        end
        in_a = 32'hFFFF_FFFF; in_b = 32'h1234_5678; in_funct = 3'd1; in_tag = 5'd9; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        total++;
        if (out_valid !== 1'b1 || out_res !== 32'h1234_5678 || out_tag !== 5'd9) begin
            bad++; $display("FAIL rst_new_op: valid=%b res=%h tag=%0d want 1 12345678 9", out_valid, out_res, out_tag);
        end
        tick;
    endtask

    task automatic test_random;
        item_t e;
        exp_q.delete();
        for (int c = 0; c < 300 + 10; c++) begin
            in_valid = (c < 300) && ($urandom_range(0, 9) < 7);
            out_ready = (c >= 300) || ($urandom_range(0, 9) < 6);
            in_a = $urandom; in_b = $urandom; in_funct = 3'($urandom_range(0, 7)); in_tag = 5'($urandom);
            #1;
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL rand_extra: tag=%0d want none", out_tag); end
                else begin
                    e = exp_q.pop_front();
                    if (out_res !== e.res || out_tag !== e.tag || out_zero !== (e.res == '0) ||
                        out_neg !== e.res[WIDTH-1] || out_parity !== ^e.res) begin
                        bad++; $display("FAIL rand_data: res=%h tag=%0d znp=%b%b%b want %h %0d", out_res, out_tag, out_zero, out_neg, out_parity, e.res, e.tag);
                    end
                end
            end
            if (in_valid && in_ready) push_in();
            tick;
        end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL rand_left: %0d want 0", exp_q.size()); end
    endtask

`ifdef LOGIC_UNIT_POPCNT_EN
    task automatic test_popcount;
        logic [WIDTH-1:0] pa [2], pr [2];
        pa = '{32'hFFFF_FFFF, 32'h0}; pr = '{32'h0000_0020, 32'h0};
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_a = pa[k]; in_b = $urandom; in_funct = 3'd7; in_tag = 5'd3; in_valid = 1'b1;
            tick;
            in_valid = 1'b0;
            tick;
            total++;
            if (out_valid !== 1'b1 || out_res !== pr[k] || out_zero !== (pr[k] == '0)) begin
                bad++; $display("FAIL popcnt k=%0d: valid=%b res=%h z=%b want 1 %h", k, out_valid, out_res, out_zero, pr[k]);
            end
            tick;
        end
    endtask
`endif

    initial begin
        test_reset;
        test_op_sweep;
        test_flags;
        test_backpressure;
        test_streaming;
        test_reset_midflight;
        test_random;
`ifdef LOGIC_UNIT_POPCNT_EN
        test_popcount;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
